// File: rtl/irq_onehot_sequencer_pkg.sv
// Shared definitions for the one-hot interrupt sequencer: sizes, FSM encoding
// and the index-to-one-hot helper used by both the picker and the top.
package irq_seq_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Bit 0 is the leftmost position, matching the downstream encoder ordering.
    function automatic logic [0:N_REQ-1] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [0:N_REQ-1] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/irq_onehot_sequencer_rr_pick.sv
// Round-robin picker: first set pending bit at or after ptr, wrapping 7 -> 0.
module rr_pick
    import irq_seq_pkg::*;
(
    input  logic [0:N_REQ-1] pending,
    input  logic [IDX_W-1:0] ptr,
    output logic [0:N_REQ-1] sel_oh,
    output logic [IDX_W-1:0] sel_idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        sel_idx = '0;
        any     = 1'b0;
        cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // 3-bit addition wraps the search naturally past line 7.
            cand = ptr + IDX_W'(k);
            if (!any && pending[cand]) begin
                any     = 1'b1;
                sel_idx = cand;
            end
        end
        sel_oh = any ? idx_to_onehot(sel_idx) : '0;
    end

endmodule

// File: rtl/irq_onehot_sequencer.sv
// Edge-detecting interrupt sequencer: latches request events as pending bits and
// hands them out one at a time as a one-hot grant, abandoning unacked grants.
module irq_onehot_sequencer
    import irq_seq_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [0:7]   req,
    input  logic         ack,
    output logic [0:7]   grant,
    output logic         valid,
    output logic [0:7]   pending,
    output logic         lost,
    output logic         timeout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [0:0]       state_q, state_d;
    logic [0:N_REQ-1] req_q;
    logic [0:N_REQ-1] pend_q, pend_d;
    logic [0:N_REQ-1] grant_q, grant_d;
    logic             valid_q, valid_d;
    logic             lost_q, lost_d;
    logic             to_q, to_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [0:N_REQ-1] event_w;
    logic [0:N_REQ-1] clr;
    logic [0:N_REQ-1] pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    assign event_w = req & ~req_q;

    rr_pick u_pick (
        .pending (pend_q),
        .ptr     (ptr_q),
        .sel_oh  (pick_oh),
        .sel_idx (pick_idx),
        .any     (pick_any)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        to_d    = 1'b0;
        clr     = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_oh;
                    valid_d = 1'b1;
                    sel_d   = pick_idx;
                    cnt_d   = '0;
                    state_d = ST_GRANT;
                end else begin
                    grant_d = '0;
                    valid_d = 1'b0;
                end
            end
            ST_GRANT: begin
                // Ack and expiry share the exit path; ack suppresses the timeout pulse.
                if (ack || (cnt_q == CNT_LAST)) begin
                    clr     = idx_to_onehot(sel_q);
                    ptr_d   = sel_q + IDX_W'(1);
                    grant_d = '0;
                    valid_d = 1'b0;
                    to_d    = ~ack;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
        // A new event on the line being cleared re-arms it rather than being lost.
        pend_d = (pend_q & ~clr) | event_w;
        lost_d = |(event_w & pend_q & ~clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= '1;
            pend_q  <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            lost_q  <= 1'b0;
            to_q    <= 1'b0;
            ptr_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req;
            pend_q  <= pend_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            lost_q  <= lost_d;
            to_q    <= to_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant   = grant_q;
    assign valid   = valid_q;
    assign pending = pend_q;
    assign lost    = lost_q;
    assign timeout = to_q;

endmodule

// File: tb/tb_irq_onehot_sequencer.sv
// Bench for irq_onehot_sequencer: directed scenarios plus a randomized run,
// scored against a set/queue-level reference model through an expectation queue.
module tb_irq_onehot_sequencer;

    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [0:7] req = '0;
    logic       ack = 1'b0;
    logic [0:7] grant;
    logic       valid;
    logic [0:7] pending;
    logic       lost;
    logic       timeout;

    irq_onehot_sequencer #(.TIMEOUT(TO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .ack     (ack),
        .grant   (grant),
        .valid   (valid),
        .pending (pending),
        .lost    (lost),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [0:7] grant;
        logic       valid;
        logic [0:7] pending;
        logic       lost;
        logic       timeout;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc_no = 0;

    // Reference model: pending set, current owner line (or none), pointer, wait age.
    bit m_prev[8];
    bit m_pend[8];
    bit m_busy;
    int m_sel, m_ptr, m_wait;

    function automatic void model_step(input logic [0:7] r, input logic a, input logic rn);
        exp_t e;
        bit   ev[8];
        int   cleared;
        bit   lo, to;
        e = '0;
        lo = 0;
        to = 0;
        if (!rn) begin
            for (int i = 0; i < 8; i++) begin
                m_prev[i] = 1;
                m_pend[i] = 0;
            end
            m_busy = 0;
            m_ptr  = 0;
            m_wait = 0;
            m_sel  = 0;
        end else begin
            for (int i = 0; i < 8; i++) ev[i] = r[i] && !m_prev[i];
            cleared = -1;
            if (m_busy) begin
                if (a || m_wait == TO - 1) begin
                    cleared = m_sel;
                    m_busy  = 0;
                    m_ptr   = (m_sel + 1) % 8;
                    to      = !a;
                end else begin
                    m_wait++;
                end
            end else begin
                for (int k = 0; k < 8; k++) begin
                    if (!m_busy && m_pend[(m_ptr + k) % 8]) begin
                        m_busy = 1;
                        m_sel  = (m_ptr + k) % 8;
                        m_wait = 0;
                    end
                end
            end
            for (int i = 0; i < 8; i++) begin
                if (ev[i] && m_pend[i] && i != cleared) lo = 1;
                m_pend[i] = (m_pend[i] && i != cleared) || ev[i];
                m_prev[i] = r[i];
            end
        end
        if (m_busy) e.grant[m_sel] = 1'b1;
        e.valid = m_busy;
        for (int i = 0; i < 8; i++) e.pending[i] = m_pend[i];
        e.lost    = lo;
        e.timeout = to;
        exp_q.push_back(e);
    endfunction

    task automatic cyc(input logic [0:7] r, input logic a, input logic rn);
        @(negedge clk);
        req   = r;
        ack   = a;
        rst_n = rn;
        model_step(r, a, rn);
        cyc_no++;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc_no, act, want);
        end
    endtask

    task automatic wait_valid(input logic [0:7] r, output logic [0:7] g);
        int n;
        n = 0;
        while (valid !== 1'b1 && n < 40) begin
            cyc(r, 1'b0, 1'b1);
            after_edge();
            n++;
        end
        g = grant;
        check("wait_valid", 32'(valid), 32'(1'b1));
    endtask

    task automatic do_reset();
        cyc('0, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b1);
        after_edge();
    endtask

    // Scoreboard monitor: every presented output cycle is matched to the next expectation.
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {grant, valid, pending, lost, timeout};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL scoreboard cycle=%0d actual=%0h required=%0h", cyc_no, a, e);
                end
                total++;
                if (!(($countones(grant) <= 1) && ((grant != '0) == valid))) begin
                    bad++;
                    $display("FAIL onehot cycle=%0d actual grant=%b valid=%b required onehot-iff-valid",
                             cyc_no, grant, valid);
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc_no);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [0:7] cur, g;
        logic [0:7] order[3];
        int n, lostc, g5;

        // Reset with all lines held high: no events after release.
        for (int i = 0; i < 3; i++) cyc(8'hFF, 1'b0, 1'b0);
        after_edge();
        check("rst_grant", 32'(grant), 32'(8'h00));
        check("rst_valid", 32'(valid), 32'(1'b0));
        check("rst_pending", 32'(pending), 32'(8'h00));
        check("rst_pulses", 32'({lost, timeout}), 32'(2'b00));
        for (int i = 0; i < 10; i++) begin
            cyc(8'hFF, 1'b0, 1'b1);
            after_edge();
            check("held_high_idle", 32'({pending, valid}), 32'(9'h000));
        end

        // Single line 3: pending, grant one cycle later, clear on ack.
        do_reset();
        cur = 8'b0001_0000;
        cyc(cur, 1'b0, 1'b1);
        after_edge();
        check("l3_pending", 32'(pending), 32'(8'b0001_0000));
        check("l3_not_yet", 32'(valid), 32'(1'b0));
        cyc(cur, 1'b0, 1'b1);
        after_edge();
        check("l3_grant", 32'({grant, valid}), 32'({8'b0001_0000, 1'b1}));
        cyc(cur, 1'b0, 1'b1);
        after_edge();
        cyc(cur, 1'b0, 1'b1);
        after_edge();
        check("l3_hold", 32'(grant), 32'(8'b0001_0000));
        cyc(cur, 1'b1, 1'b1);
        after_edge();
        check("l3_cleared", 32'({grant, valid, pending}), 32'(17'h0));

        // Lines 0,4,7 together: served 0,4,7; re-raised 0 served after wrap.
        do_reset();
        cur = 8'b1000_1001;
        for (int i = 0; i < 3; i++) begin
            wait_valid(cur, g);
            order[i] = g;
            cyc(cur, 1'b1, 1'b1);
            after_edge();
        end
        check("rr_first", 32'(order[0]), 32'(8'b1000_0000));
        check("rr_second", 32'(order[1]), 32'(8'b0000_1000));
        check("rr_third", 32'(order[2]), 32'(8'b0000_0001));
        cyc(8'b0000_1001, 1'b0, 1'b1);
        after_edge();
        cur = 8'b1000_1011;
        wait_valid(cur, g);
        check("rr_wrap", 32'(g), 32'(8'b1000_0000));
        cyc(cur, 1'b1, 1'b1);
        after_edge();
        wait_valid(cur, g);
        check("rr_after_wrap", 32'(g), 32'(8'b0000_0010));
        cyc(cur, 1'b1, 1'b1);
        after_edge();

        // Line 2 never acked: timeout TO cycles after valid rose.
        do_reset();
        cur = 8'b0010_0000;
        wait_valid(cur, g);
        check("to_grant", 32'(g), 32'(8'b0010_0000));
        n = 0;
        while (timeout !== 1'b1 && n < 40) begin
            cyc(cur, 1'b0, 1'b1);
            after_edge();
            n++;
        end
        check("to_latency", 32'(n), 32'(TO));
        check("to_state", 32'({pending, valid}), 32'(9'h000));
        cyc(cur, 1'b0, 1'b1);
        after_edge();
        check("to_one_pulse", 32'(timeout), 32'(1'b0));

        // Line 5 re-fires while pending behind line 1: one lost, one grant.
        do_reset();
        cur = 8'b0100_0000;
        wait_valid(cur, g);
        lostc = 0;
        cur = 8'b0100_0100;
        cyc(cur, 1'b0, 1'b1);
        after_edge();
        lostc += int'(lost);
        check("l5_pending", 32'(pending), 32'(8'b0100_0100));
        cur = 8'b0100_0000;
        cyc(cur, 1'b0, 1'b1);
        after_edge();
        lostc += int'(lost);
        cur = 8'b0100_0100;
        cyc(cur, 1'b0, 1'b1);
        after_edge();
        lostc += int'(lost);
        cyc(cur, 1'b0, 1'b1);
        after_edge();
        lostc += int'(lost);
        check("l5_lost_once", 32'(lostc), 32'd1);
        cyc(cur, 1'b1, 1'b1);
        after_edge();
        wait_valid(cur, g);
        check("l5_grant", 32'(g), 32'(8'b0000_0100));
        cyc(cur, 1'b1, 1'b1);
        after_edge();
        g5 = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(cur, 1'b0, 1'b1);
            after_edge();
            g5 += int'(valid);
        end
        check("l5_single_grant", 32'(g5), 32'd0);

        // Line 6: ack coincides with a fresh event on the same line.
        do_reset();
        cur = 8'b0000_0010;
        wait_valid(cur, g);
        check("l6_grant", 32'(g), 32'(8'b0000_0010));
        cyc(8'h00, 1'b0, 1'b1);
        after_edge();
        cyc(cur, 1'b1, 1'b1);
        after_edge();
        check("l6_set_wins", 32'({valid, pending, lost}), 32'({1'b0, 8'b0000_0010, 1'b0}));
        cyc(cur, 1'b0, 1'b1);
        after_edge();
        check("l6_regrant", 32'({grant, valid}), 32'({8'b0000_0010, 1'b1}));
        cyc(cur, 1'b1, 1'b1);
        after_edge();

        // Randomized traffic, alternating ack-heavy and ack-starved phases.
        cur = '0;
        for (int i = 0; i < 3000; i++) begin
            logic a, rn;
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 7) == 0) cur[b] = ~cur[b];
            if ((i % 600) < 300) a = ($urandom_range(0, 2) == 0);
            else                 a = ($urandom_range(0, 19) == 0);
            rn = ($urandom_range(0, 399) != 0);
            cyc(cur, a, rn);
        end
        cyc('0, 1'b0, 1'b1);
        @(posedge clk);
        #3;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
